// File: rtl/multi_wave_oscillator.sv
// multi_wave_oscillator: divided phase accumulator shaped into saw/square/triangle/ramp-down, with settings shadowed at wrap
// Ports: clk; nRst (async, active-high); enable; period[DIV_W]; oct_dwn[2]; wave_sel[2];
//   duty[OUT_W] (only with OSC_DUTY_EN); wave_out[OUT_W]; step_pulse; wrap_pulse.
// Define OSC_DUTY_EN to add the duty port and a variable-duty square wave.
module multi_wave_oscillator #(
  parameter int OUT_W = 8,
  parameter int DIV_W = 10,
  parameter int OCT_MAX = 3
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             enable,
  input  logic [DIV_W-1:0] period,
  input  logic [1:0]       oct_dwn,
  input  logic [1:0]       wave_sel,
`ifdef OSC_DUTY_EN
  input  logic [OUT_W-1:0] duty,
`endif
  output logic [OUT_W-1:0] wave_out,
  output logic             step_pulse,
  output logic             wrap_pulse
);
  localparam int CW = DIV_W + OCT_MAX;
  logic [CW-1:0] cnt, p_eff;
  logic [OUT_W-1:0] phase, shaped, tri_v, tri_t, sq;
  logic [DIV_W-1:0] sp, sp_e;
  logic [1:0] so, so_e, sw;
  logic en_q, stp, wrp, last, wrap_now, load0;
`ifdef OSC_DUTY_EN
  logic [OUT_W-1:0] sd;
`endif
  // At the start of a cycle (or while idle) the shadows are being reloaded anyway,
  // so the divider uses the incoming settings right away to keep restarts exact.
  always_comb begin
    load0 = !enable || (phase == '0 && cnt == '0);
    sp_e = load0 ? period : sp;
    so_e = load0 ? oct_dwn : so;
    p_eff = {{OCT_MAX{1'b0}}, (sp_e == '0) ? DIV_W'(1) : sp_e} << so_e;
    last = cnt == p_eff - CW'(1);
    wrap_now = enable && last && (&phase);
    tri_t = {phase[OUT_W-2:0], 1'b0};
    tri_v = phase[OUT_W-1] ? ~tri_t : tri_t;
`ifdef OSC_DUTY_EN
    sq = {OUT_W{phase < sd}};
`else
    sq = {OUT_W{~phase[OUT_W-1]}};
`endif
    shaped = (sw == 2'd0) ? phase : (sw == 2'd1) ? sq : (sw == 2'd2) ? tri_v : ~phase;
  end
  // stp/wrp delay the pulses one cycle so they line up with wave_out showing the new phase.
  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      cnt <= '0;
      phase <= '0;
      sp <= '0;
      so <= '0;
      sw <= '0;
`ifdef OSC_DUTY_EN
      sd <= '0;
`endif
      en_q <= 1'b0;
      stp <= 1'b0;
      wrp <= 1'b0;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      wave_out <= '0;
    end else begin
      if (load0 || wrap_now) begin
        sp <= period;
        so <= oct_dwn;
        sw <= wave_sel;
`ifdef OSC_DUTY_EN
        sd <= duty;
`endif
      end
      en_q <= enable;
      cnt <= (!enable || last) ? '0 : cnt + CW'(1);
      phase <= !enable ? '0 : last ? phase + OUT_W'(1) : phase;
      stp <= enable && last;
      wrp <= wrap_now;
      step_pulse <= enable && stp;
      wrap_pulse <= enable && wrp;
      wave_out <= en_q ? shaped : '0;
    end
  end
endmodule

// File: tb/tb_multi_wave_oscillator.sv
// tb_multi_wave_oscillator: directed self-checking bench for multi_wave_oscillator
module tb_multi_wave_oscillator;
  logic clk = 1'b0, nRst = 1'b1, enable = 1'b0, step_pulse, wrap_pulse;
  logic [9:0] period = 10'd3;
  logic [1:0] oct_dwn = 2'd0, wave_sel = 2'd0;
  logic [7:0] wave_out;
  int n_cmp = 0, n_err = 0, n;
`ifdef OSC_DUTY_EN
  logic [7:0] duty = 8'd64;
  localparam int SPLIT = 64;
`else
  localparam int SPLIT = 128;
`endif
  multi_wave_oscillator dut (
    .clk(clk), .nRst(nRst), .enable(enable), .period(period), .oct_dwn(oct_dwn),
    .wave_sel(wave_sel),
`ifdef OSC_DUTY_EN
    .duty(duty),
`endif
    .wave_out(wave_out), .step_pulse(step_pulse), .wrap_pulse(wrap_pulse));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_until(input bit w, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!(w ? wrap_pulse : step_pulse) && cnt < 4000);
  endtask
  initial begin
    repeat (2) tick();
    check("rst_wave", wave_out, 0);
    check("rst_step", step_pulse, 0);
    check("rst_wrap", wrap_pulse, 0);
    nRst = 1'b0;
    tick();
    enable = 1'b1;
    run_until(0, n);
    check("saw_first_step", n, 4);
    check("saw_wave1", wave_out, 1);
    run_until(0, n);
    check("saw_gap", n, 3);
    check("saw_wave2", wave_out, 2);
    run_until(1, n);
    check("saw_wrap_time", n, 762);
    check("saw_wrap_wave", wave_out, 0);
    check("saw_wrap_step", step_pulse, 1);
    run_until(0, n);
    check("post_wrap_wave", wave_out, 1);
    tick();
    #2 nRst = 1'b1;
    #1;
    check("async_rst_wave", wave_out, 0);
    check("async_rst_step", step_pulse, 0);
    nRst = 1'b0;
    run_until(0, n);
    check("rst_restart_step", n, 4);
    enable = 1'b0;
    oct_dwn = 2'd2;
    repeat (2) tick();
    enable = 1'b1;
    run_until(0, n);
    check("oct2_first_step", n, 13);
    repeat (99) run_until(0, n);
    check("oct2_gap", n, 12);
    check("oct2_phase100", wave_out, 100);
    oct_dwn = 2'd0;
    run_until(0, n);
    check("oct_hold_gap", n, 12);
    check("oct_hold_wave", wave_out, 101);
    run_until(1, n);
    check("oct_wrap_time", n, 1860);
    run_until(0, n);
    check("oct_new_gap", n, 3);
    enable = 1'b0;
    period = 10'd0;
    wave_sel = 2'd2;
    repeat (2) tick();
    enable = 1'b1;
    run_until(0, n);
    check("p0_first_step", n, 2);
    check("tri_1", wave_out, 2);
    tick();
    check("p0_step_each", step_pulse, 1);
    repeat (62) tick();
    check("tri_64", wave_out, 128);
    repeat (63) tick();
    check("tri_127", wave_out, 254);
    tick();
    check("tri_128", wave_out, 255);
    wave_sel = 2'd0;
    repeat (127) tick();
    check("tri_255_held", wave_out, 1);
    tick();
    check("tri_wrap_wave", wave_out, 0);
    check("tri_wrap_pulse", wrap_pulse, 1);
    tick();
    check("saw_after_wrap", wave_out, 1);
    wave_sel = 2'd3;
    enable = 1'b0;
    tick();
    check("dis_step", step_pulse, 0);
    tick();
    check("dis_wave", wave_out, 0);
    check("dis_wrap", wrap_pulse, 0);
    tick();
    check("dis_wave_hold", wave_out, 0);
    enable = 1'b1;
    run_until(0, n);
    check("reen_step", n, 2);
    check("ramp_1", wave_out, 254);
    enable = 1'b0;
    wave_sel = 2'd1;
    repeat (2) tick();
    enable = 1'b1;
    run_until(0, n);
    check("sq_1", wave_out, 255);
    repeat (SPLIT - 2) tick();
    check("sq_below_split", wave_out, 255);
    tick();
    check("sq_at_split", wave_out, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
